// File: rtl/kb_pkg.sv
// Shared types and constants for the PS/2 keyboard event path.
package kb_pkg;

    localparam int unsigned KB_CODE_W     = 8;
    localparam int unsigned KB_FRAME_BITS = 11;
    localparam int unsigned KB_CNT_W      = 4;

    localparam logic [KB_CODE_W-1:0] KB_PREFIX_EXT = 8'hE0;
    localparam logic [KB_CODE_W-1:0] KB_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    // "release" is a reserved word, hence the is_ prefixes on the flags.
    typedef struct packed {
        logic [KB_CODE_W-1:0] code;
        logic                 is_release;
        logic                 is_extended;
    } kb_event_t;

    // Frame word is held with the start bit in bit 0 and the stop bit in bit 10.
    function automatic logic kb_frame_ok(input logic [KB_FRAME_BITS-1:0] w);
        return (w[0] == 1'b0) && (w[KB_FRAME_BITS-1] == 1'b1) && (^w[9:1]);
    endfunction

    function automatic logic [KB_CODE_W-1:0] kb_frame_byte(input logic [KB_FRAME_BITS-1:0] w);
        return w[8:1];
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Small synchronous event queue; head entry is presented combinationally from storage.
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  kb_event_t push_data,
    input  logic      pop,
    output kb_event_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    kb_event_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push-while-full succeeds alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage, pointers (wrap naturally at the power-of-two depth) and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);
        end
    end

endmodule

// File: rtl/kb_event_ctrl.sv
// PS/2 keyboard receive path: synchronizer, frame receiver with watchdog,
// scan-code prefix decoder and a valid/ready event queue.
module kb_event_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           kb_in,
    input  logic                 event_ready,
    output logic                 event_valid,
    output logic [KB_CODE_W-1:0] event_code,
    output logic                 event_release,
    output logic                 event_extended,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reads 0 the cycle after an edge flag, so hitting TIMEOUT_CYCLES-2
    // puts the registered frame_err exactly TIMEOUT_CYCLES cycles after that flag.
    localparam int unsigned WD_HIT = TIMEOUT_CYCLES - 2;

    logic [SYNC_STAGES-1:0]   clk_sync;
    logic [SYNC_STAGES-1:0]   dat_sync;
    logic                     kb_clk_s;
    logic                     kb_dat_s;
    logic                     kb_clk_prev;
    logic                     edge_q;

    rx_state_e                state_q;
    rx_state_e                state_d;
    logic [KB_FRAME_BITS-1:0] shift_q;
    logic [KB_CNT_W-1:0]      bit_cnt;
    logic [WD_W-1:0]          wd_cnt;

    logic                     shift_en;
    logic                     cnt_load;
    logic                     start_err;
    logic                     timeout_hit;
    logic                     check_en;

    logic                     frame_ok;
    logic [KB_CODE_W-1:0]     rx_byte;
    logic                     is_prefix;
    logic                     push_c;
    logic                     err_c;
    logic                     pop_c;
    logic                     ext_q;
    logic                     brk_q;

    kb_event_t                push_evt;
    kb_event_t                head_evt;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign kb_clk_s = clk_sync[SYNC_STAGES-1];
    assign kb_dat_s = dat_sync[SYNC_STAGES-1];

    // Metastability chains; idle-high so a reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync[0] <= kb_in[0];
            dat_sync[0] <= kb_in[1];
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                clk_sync[i] <= clk_sync[i-1];
                dat_sync[i] <= dat_sync[i-1];
            end
        end
    end

    // One-cycle flag per falling edge of the synchronized keyboard clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            kb_clk_prev <= 1'b1;
            edge_q      <= 1'b0;
        end else begin
            kb_clk_prev <= kb_clk_s;
            edge_q      <= kb_clk_prev & ~kb_clk_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver next state and per-cycle control strobes.
    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        cnt_load    = 1'b0;
        start_err   = 1'b0;
        timeout_hit = 1'b0;
        check_en    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (edge_q) begin
                    if (!kb_dat_s) begin
                        shift_en = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = RX_SHIFT;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            RX_SHIFT: begin
                if (edge_q) begin
                    shift_en = 1'b1;
                    if (bit_cnt == KB_CNT_W'(KB_FRAME_BITS - 1)) begin
                        state_d = RX_CHECK;
                    end
                end else if (wd_cnt == WD_W'(WD_HIT)) begin
                    timeout_hit = 1'b1;
                    state_d     = RX_IDLE;
                end
            end
            RX_CHECK: begin
                check_en = 1'b1;
                state_d  = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // Frame shifter (LSB-first, so the start bit ends up in bit 0) and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en) begin
                shift_q <= {kb_dat_s, shift_q[KB_FRAME_BITS-1:1]};
            end
            if (cnt_load) begin
                bit_cnt <= KB_CNT_W'(1);
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + KB_CNT_W'(1);
            end
        end
    end

    // Watchdog: cycles since the last edge while a frame is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if ((state_q != RX_SHIFT) || edge_q) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign frame_ok  = kb_frame_ok(shift_q);
    assign rx_byte   = kb_frame_byte(shift_q);
    assign is_prefix = (rx_byte == KB_PREFIX_EXT) || (rx_byte == KB_PREFIX_BRK);
    assign push_c    = check_en && frame_ok && !is_prefix;
    assign err_c     = start_err || timeout_hit || (check_en && !frame_ok);
    assign pop_c     = event_valid && event_ready;

    assign push_evt.code        = rx_byte;
    assign push_evt.is_release  = brk_q;
    assign push_evt.is_extended = ext_q;

    // Prefix flags accumulate until a real code is queued or any frame error occurs.
    always_ff @(posedge clk) begin
        if (reset || err_c) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (check_en && frame_ok) begin
            if (rx_byte == KB_PREFIX_EXT) begin
                ext_q <= 1'b1;
            end else if (rx_byte == KB_PREFIX_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // Status pulses, one cycle after their cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= err_c;
            overflow  <= push_c && fifo_full && !pop_c;
        end
    end

    kb_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_evt),
        .pop       (pop_c),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign event_valid    = ~fifo_empty;
    assign event_code     = head_evt.code;
    assign event_release  = head_evt.is_release;
    assign event_extended = head_evt.is_extended;

endmodule

// File: tb/tb_kb_event_ctrl.sv
// Bench for kb_event_ctrl: PS/2 frame driver, event-queue reference model and
// a per-cycle comparator, plus hand-computed literal expectations.
module tb_kb_event_ctrl;
    import kb_pkg::*;

    localparam int unsigned TIMEOUT = 5000;
    localparam int unsigned DEPTH   = 4;
    localparam int          HALF    = 20;

    localparam int S_VALID = 0;
    localparam int S_CODE  = 1;
    localparam int S_REL   = 2;
    localparam int S_EXT   = 3;
    localparam int S_ERR   = 4;
    localparam int S_OVF   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] kb_in;
    logic       event_ready;
    logic       event_valid;
    logic [7:0] event_code;
    logic       event_release;
    logic       event_extended;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    kb_event_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .kb_in          (kb_in),
        .event_ready    (event_ready),
        .event_valid    (event_valid),
        .event_code     (event_code),
        .event_release  (event_release),
        .event_extended (event_extended),
        .frame_err      (frame_err),
        .overflow       (overflow)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected pushes keyed by the cycle the frame is judged,
    // expected error pulses keyed by the cycle they are visible.
    kb_event_t mq[$];
    kb_event_t push_at[int];
    bit        err_at[int];
    bit        ovf_at[int];
    bit        m_ext;
    bit        m_brk;

    // Queue behaviour at each clock edge: pop what the consumer took, then append.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && event_ready) void'(mq.pop_front());
            if (push_at.exists(cyc)) begin
                if (mq.size() < int'(DEPTH)) mq.push_back(push_at[cyc]);
                else ovf_at[cyc + 1] = 1'b1;
            end
        end
    end

    typedef struct {
        int         at;
        int         sel;
        logic [7:0] val;
        string      name;
    } lit_t;
    lit_t lits[$];

    function automatic void expect_at(input int at, input int sel, input logic [7:0] val,
                                      input string name);
        lit_t l;
        l.at = at; l.sel = sel; l.val = val; l.name = name;
        lits.push_back(l);
    endfunction

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            S_VALID: return {7'b0, event_valid};
            S_CODE:  return event_code;
            S_REL:   return {7'b0, event_release};
            S_EXT:   return {7'b0, event_extended};
            S_ERR:   return {7'b0, frame_err};
            default: return {7'b0, overflow};
        endcase
    endfunction

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit exp_valid;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model, plus literal pins.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = (mq.size() != 0);
            cmp("event_valid", {7'b0, event_valid}, {7'b0, exp_valid});
            if (exp_valid && event_valid) begin
                cmp("event_code", event_code, mq[0].code);
                cmp("event_release", {7'b0, event_release}, {7'b0, mq[0].is_release});
                cmp("event_extended", {7'b0, event_extended}, {7'b0, mq[0].is_extended});
            end
            cmp("frame_err", {7'b0, frame_err}, {7'b0, err_at.exists(cyc)});
            cmp("overflow", {7'b0, overflow}, {7'b0, ovf_at.exists(cyc)});
            foreach (lits[i]) begin
                if (lits[i].at == cyc) cmp(lits[i].name, pick(lits[i].sel), lits[i].val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Drive the first nbits of a frame; returns with the keyboard clock low after the last bit.
    task automatic send_word(input logic [10:0] w, input int nbits, output int last_fall);
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i != 0) begin
                repeat (HALF) tick();
                kb_in[0] = 1'b1;
            end
            kb_in[1] = w[i];
            repeat (HALF) tick();
            kb_in[0]  = 1'b0;
            last_fall = cyc;
        end
    endtask

    task automatic kb_release();
        repeat (HALF) tick();
        kb_in = 2'b11;
        repeat (HALF) tick();
    endtask

    // Byte-level decode of a complete word whose stop bit fell in cycle k.
    task automatic model_word(input logic [10:0] w, input int k);
        logic [7:0] b;
        kb_event_t  e;
        b = w[8:1];
        if (w[0] == 1'b0 && w[10] == 1'b1 && ($countones(w[9:1]) % 2) == 1) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                e.code = b; e.is_release = m_brk; e.is_extended = m_ext;
                push_at[k + 4] = e;
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end else begin
            err_at[k + 5] = 1'b1;
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad, output int k);
        send_word(mk(b, bad), 11, k);
        model_word(mk(b, bad), k);
    endtask

    task automatic byte_full(input logic [7:0] b);
        int k;
        frame(b, 1'b0, k);
        kb_release();
    endtask

    task automatic expect_event(input int at, input logic [7:0] code, input bit rel, input bit ext);
        expect_at(at, S_VALID, 8'd1, "lit_valid");
        expect_at(at, S_CODE, code, "lit_code");
        expect_at(at, S_REL, {7'b0, rel}, "lit_release");
        expect_at(at, S_EXT, {7'b0, ext}, "lit_extended");
    endtask

    task automatic expect_all_zero(input int at);
        for (int s = S_VALID; s <= S_OVF; s++) expect_at(at, s, 8'd0, "lit_reset_zero");
    endtask

    initial begin
        int k, c, r;
        reset = 1'b1; kb_in = 2'b11; event_ready = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        expect_all_zero(cyc);
        reset = 1'b0;
        repeat (5) tick();

        // Plain make code with exact latency.
        frame(8'h1C, 1'b0, k);
        expect_at(k + 4, S_VALID, 8'd0, "lit_make_early");
        expect_event(k + 5, 8'h1C, 1'b0, 1'b0);
        expect_at(k + 5, S_ERR, 8'd0, "lit_make_noerr");
        kb_release();

        // Break, then extended break.
        byte_full(8'hF0);
        frame(8'h1C, 1'b0, k);
        expect_event(k + 5, 8'h1C, 1'b1, 1'b0);
        kb_release();
        byte_full(8'hE0);
        byte_full(8'hF0);
        frame(8'h75, 1'b0, k);
        expect_event(k + 5, 8'h75, 1'b1, 1'b1);
        kb_release();

        // Parity error discards the pending break prefix.
        byte_full(8'hF0);
        frame(8'h1C, 1'b1, k);
        expect_at(k + 4, S_ERR, 8'd0, "lit_par_err_early");
        expect_at(k + 5, S_ERR, 8'd1, "lit_par_err");
        expect_at(k + 6, S_ERR, 8'd0, "lit_par_err_single");
        expect_at(k + 5, S_VALID, 8'd0, "lit_par_noevent");
        kb_release();
        byte_full(8'hE0);
        frame(8'h75, 1'b0, k);
        expect_event(k + 5, 8'h75, 1'b0, 1'b1);
        kb_release();

        // Watchdog: five bits then silence; the error also drops a pending E0.
        byte_full(8'hE0);
        send_word(mk(8'h29, 1'b0), 5, k);
        err_at[k + 3 + int'(TIMEOUT)] = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
        expect_at(k + 3 + int'(TIMEOUT) - 1, S_ERR, 8'd0, "lit_timeout_early");
        expect_at(k + 3 + int'(TIMEOUT), S_ERR, 8'd1, "lit_timeout");
        kb_release();
        wait_until(k + 3 + int'(TIMEOUT) + 5);
        frame(8'h29, 1'b0, k);
        expect_event(k + 5, 8'h29, 1'b0, 1'b0);
        kb_release();

        // Backpressure and overflow on the fifth make.
        event_ready = 1'b0;
        byte_full(8'h16);
        byte_full(8'h1E);
        byte_full(8'h26);
        byte_full(8'h25);
        frame(8'h2E, 1'b0, k);
        expect_at(k + 4, S_OVF, 8'd0, "lit_ovf_early");
        expect_at(k + 5, S_OVF, 8'd1, "lit_ovf");
        expect_at(k + 5, S_CODE, 8'h16, "lit_ovf_head_held");
        kb_release();
        event_ready = 1'b1;
        c = cyc;
        expect_at(c,     S_CODE, 8'h16, "lit_drain0");
        expect_at(c + 1, S_CODE, 8'h1E, "lit_drain1");
        expect_at(c + 2, S_CODE, 8'h26, "lit_drain2");
        expect_at(c + 3, S_CODE, 8'h25, "lit_drain3");
        expect_at(c + 4, S_VALID, 8'd0, "lit_drained");
        repeat (10) tick();

        // Push and pop in the same cycle while full.
        event_ready = 1'b0;
        byte_full(8'h45);
        byte_full(8'h16);
        byte_full(8'h1E);
        byte_full(8'h26);
        frame(8'h2E, 1'b0, k);
        expect_at(k + 5, S_OVF, 8'd0, "lit_pushpop_noovf");
        expect_at(k + 5, S_CODE, 8'h16, "lit_pushpop_head");
        wait_until(k + 4);
        event_ready = 1'b1;
        tick();
        event_ready = 1'b0;
        kb_release();
        event_ready = 1'b1;
        c = cyc;
        expect_at(c,     S_CODE, 8'h16, "lit_pp_drain0");
        expect_at(c + 1, S_CODE, 8'h1E, "lit_pp_drain1");
        expect_at(c + 2, S_CODE, 8'h26, "lit_pp_drain2");
        expect_at(c + 3, S_CODE, 8'h2E, "lit_pp_drain3");
        expect_at(c + 4, S_VALID, 8'd0, "lit_pp_drained");
        repeat (10) tick();

        // Reset mid-frame with an event queued.
        event_ready = 1'b0;
        byte_full(8'h16);
        send_word(mk(8'h1C, 1'b0), 6, k);
        kb_release();
        r = cyc + 1;
        expect_all_zero(r);
        reset = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0;
        tick();
        reset = 1'b0;
        event_ready = 1'b1;
        repeat (5) tick();
        frame(8'h1C, 1'b0, k);
        expect_event(k + 5, 8'h1C, 1'b0, 1'b0);
        kb_release();

        repeat (20) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
